// File: rtl/unum4_pkg.sv
// Shared unum4 definitions: FSM state encoding and default widths.
// The optional underflow-saturation feature is enabled by defining UNUM4_NORM_UFLOW_EN.
package unum4_pkg;

  localparam int MAN_MAX_W_DEF = 29;
  localparam int EXP_MAX_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } norm_state_t;

endpackage

// File: rtl/unum4_clz.sv
// Leading sign-bit counter: number of equal adjacent bit pairs from the MSB (0..MAN_MAX_W-1).
// EXTRA widens the count output beyond the minimum needed.
module unum4_clz #(
  parameter int MAN_MAX_W = 5,
  parameter int EXTRA     = 0
) (
  input  logic [MAN_MAX_W-1:0]                 man,
  output logic [$clog2(MAN_MAX_W)+EXTRA-1:0]   lz
);

  localparam int LW = $clog2(MAN_MAX_W) + EXTRA;

  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = MAN_MAX_W - 1; i > 0; i--) begin
      if (run && (man[i] == man[i-1])) begin
        lz = lz + LW'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/unum4_norm_seq.sv
// Multi-cycle unum4 normalizer: strips up to STEP redundant sign bits per cycle.
// Define UNUM4_NORM_UFLOW_EN to add uflow_out and saturate the exponent on underflow.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SCAN  | shifting out redundant sign bits, STEP per cycle
// DONE  | result presented, held until out_ready
module unum4_norm_seq
  import unum4_pkg::*;
#(
  parameter int MAN_MAX_W = MAN_MAX_W_DEF,
  parameter int EXP_MAX_W = EXP_MAX_W_DEF,
  parameter int STEP      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [MAN_MAX_W-1:0] man_in,
  input  logic [EXP_MAX_W-1:0] exp_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MAN_MAX_W-1:0] man_out,
  output logic [EXP_MAX_W-1:0] exp_out,
  output logic [EXP_MAX_W-1:0] lz_out,
  output logic                 zero_out
`ifdef UNUM4_NORM_UFLOW_EN
  ,
  output logic                 uflow_out
`endif
);

  localparam int CW  = $clog2(MAN_MAX_W);
  localparam int KW  = $clog2(STEP + 1);
  localparam int EW1 = EXP_MAX_W + 1;

  norm_state_t state, state_nxt;

  logic [MAN_MAX_W-1:0] man_r;
  logic [EXP_MAX_W-1:0] exp_r, exp_nxt;
  logic [CW-1:0]        cnt_r, cnt_nxt, room, k_ext, k;
  logic                 zero_r;
  logic [KW-1:0]        k_raw;
  logic                 scan_last;

  unum4_clz #(
    .MAN_MAX_W (STEP + 1),
    .EXTRA     (0)
  ) u_clz (
    .man (man_r[MAN_MAX_W-1 -: STEP+1]),
    .lz  (k_raw)
  );

  // Cap k so the total count never exceeds MAN_MAX_W-1 (all-zero / all-one inputs).
  always_comb begin
    room      = CW'(MAN_MAX_W - 1) - cnt_r;
    k_ext     = CW'(k_raw);
    k         = (k_ext > room) ? room : k_ext;
    cnt_nxt   = cnt_r + k;
    scan_last = (k < CW'(STEP)) || (cnt_nxt == CW'(MAN_MAX_W - 1));
  end

`ifdef UNUM4_NORM_UFLOW_EN
  logic             uflow_r, uflow_nxt;
  logic [EW1-1:0]   exp_diff;

  // Signed subtract one bit wider; a sign mismatch in the top two bits means underflow.
  always_comb begin
    exp_diff  = {exp_r[EXP_MAX_W-1], exp_r} - EW1'(k);
    exp_nxt   = exp_diff[EXP_MAX_W-1:0];
    uflow_nxt = uflow_r;
    if (exp_diff[EXP_MAX_W] != exp_diff[EXP_MAX_W-1]) begin
      exp_nxt   = {1'b1, {(EXP_MAX_W-1){1'b0}}};
      uflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uflow_r <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      uflow_r <= 1'b0;
    end else if (state == SCAN) begin
      uflow_r <= uflow_nxt;
    end
  end

  assign uflow_out = (state == DONE) ? uflow_r : 1'b0;
`else
  always_comb begin
    exp_nxt = exp_r - EXP_MAX_W'(k);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SCAN;
      SCAN:    if (scan_last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      man_r  <= '0;
      exp_r  <= '0;
      cnt_r  <= '0;
      zero_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            man_r  <= man_in;
            exp_r  <= exp_in;
            cnt_r  <= '0;
            zero_r <= (man_in == '0);
          end
        end
        SCAN: begin
          man_r <= man_r << k;
          exp_r <= exp_nxt;
          cnt_r <= cnt_nxt;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign man_out   = out_valid ? man_r : '0;
  assign exp_out   = out_valid ? exp_r : '0;
  assign lz_out    = out_valid ? EXP_MAX_W'(cnt_r) : '0;
  assign zero_out  = out_valid ? zero_r : 1'b0;

endmodule

// File: tb/tb_unum4_norm_seq.sv
// Self-checking bench for unum4_norm_seq: vector table plus scoreboard, backpressure and reset corners.
// Honours UNUM4_NORM_UFLOW_EN when the design is built with it.
module tb_unum4_norm_seq;

  localparam int MW = 29;
  localparam int EW = 16;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] man_in;
  logic [EW-1:0] exp_in;
  logic          out_valid;
  logic          out_ready;
  logic [MW-1:0] man_out;
  logic [EW-1:0] exp_out;
  logic [EW-1:0] lz_out;
  logic          zero_out;
  logic          uflow_obs;
`ifdef UNUM4_NORM_UFLOW_EN
  logic          uflow_out;
  assign uflow_obs = uflow_out;
`else
  assign uflow_obs = 1'b0;
`endif

  always #5 clk = ~clk;

  unum4_norm_seq #(.MAN_MAX_W(MW), .EXP_MAX_W(EW), .STEP(ST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .man_in    (man_in),
    .exp_in    (exp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .man_out   (man_out),
    .exp_out   (exp_out),
    .lz_out    (lz_out),
    .zero_out  (zero_out)
`ifdef UNUM4_NORM_UFLOW_EN
    ,
    .uflow_out (uflow_out)
`endif
  );

  typedef struct {
    logic [MW-1:0] man;
    logic [EW-1:0] ex;
    int            scans;
    logic [MW-1:0] man_e;
    logic [EW-1:0] exp_e;
    logic [EW-1:0] lz_e;
    logic          zero_e;
    logic          uflow_e;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [MW-1:0] m, input logic [EW-1:0] e, input int sc,
                              input logic [MW-1:0] me, input logic [EW-1:0] ee,
                              input logic [EW-1:0] le, input logic ze, input logic ue);
    vec_t v;
    v.man = m; v.ex = e; v.scans = sc; v.man_e = me;
    v.exp_e = ee; v.lz_e = le; v.zero_e = ze; v.uflow_e = ue;
    return v;
  endfunction

  // Reference: count leading redundant sign bits directly, then apply latency formula.
  function automatic vec_t model(input logic [MW-1:0] m, input logic [EW-1:0] e);
    vec_t v;
    int   n = 0;
    bit   go = 1'b1;
    int   full;
    int   diff;
    for (int i = MW - 1; i > 0; i--) begin
      if (go && (m[i] == m[i-1])) n++;
      else go = 1'b0;
    end
    full     = (MW - 1 + ST - 1) / ST;
    v.man    = m;
    v.ex     = e;
    v.scans  = (n / ST + 1 < full) ? n / ST + 1 : full;
    v.man_e  = m << n;
    v.lz_e   = EW'(n);
    v.zero_e = (m == '0);
    v.exp_e  = e - EW'(n);
    v.uflow_e = 1'b0;
`ifdef UNUM4_NORM_UFLOW_EN
    diff = int'($signed(e)) - n;
    if (diff < -(1 << (EW - 1))) begin
      v.exp_e   = {1'b1, {(EW-1){1'b0}}};
      v.uflow_e = 1'b1;
    end
`else
    diff = 0;
`endif
    return v;
  endfunction

  task automatic run_op(input vec_t v, input bit junk, input int hold);
    int   cyc;
    vec_t e;
    logic [MW-1:0] hm;
    logic [EW-1:0] he;
    logic [EW-1:0] hl;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      step();
      cyc++;
    end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    man_in   = v.man;
    exp_in   = v.ex;
    in_valid = 1'b1;
    step();
    sb.push_back(v);
    in_valid = 1'b0;
    man_in   = 'x;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (junk) begin
        in_valid = 1'($urandom_range(0, 1));
        man_in   = MW'($urandom);
        exp_in   = EW'($urandom);
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    chk("out_valid_seen", {63'd0, out_valid}, 64'd1);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    chk("scan_cycles", 64'(cyc), 64'(e.scans));
    chk("man_out", 64'(man_out), 64'(e.man_e));
    chk("exp_out", 64'(exp_out), 64'(e.exp_e));
    chk("lz_out", 64'(lz_out), 64'(e.lz_e));
    chk("zero_out", {63'd0, zero_out}, {63'd0, e.zero_e});
    chk("uflow_out", {63'd0, uflow_obs}, {63'd0, e.uflow_e});
    chk("in_ready_done", {63'd0, in_ready}, 64'd0);
    hm = man_out; he = exp_out; hl = lz_out;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_man", 64'(man_out), 64'(hm));
      chk("hold_exp", 64'(exp_out), 64'(he));
      chk("hold_lz", 64'(lz_out), 64'(hl));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_hs_valid", {63'd0, out_valid}, 64'd0);
    chk("post_hs_ready", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic signed [MW-1:0] s;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    man_in    = '0;
    exp_in    = '0;

    tbl.push_back(mk(29'h0800_0000, 16'd5,   1, 29'h0800_0000, 16'd5,     16'd0,  1'b0, 1'b0));
    tbl.push_back(mk(29'h0000_0001, 16'd0,   7, 29'h0800_0000, 16'hFFE5,  16'd27, 1'b0, 1'b0));
    tbl.push_back(mk(29'h1F00_0000, 16'd10,  2, 29'h1000_0000, 16'd6,     16'd4,  1'b0, 1'b0));
    tbl.push_back(mk(29'h0000_0000, 16'd3,   7, 29'h0000_0000, 16'hFFE7,  16'd28, 1'b1, 1'b0));
    tbl.push_back(mk(29'h1FFF_FFFF, 16'd100, 7, 29'h1000_0000, 16'd72,    16'd28, 1'b0, 1'b0));
    tbl.push_back(mk(29'h0400_0000, 16'd0,   1, 29'h0800_0000, 16'hFFFF,  16'd1,  1'b0, 1'b0));
    tbl.push_back(mk(29'h0080_0000, 16'd0,   2, 29'h0800_0000, 16'hFFFC,  16'd4,  1'b0, 1'b0));
`ifdef UNUM4_NORM_UFLOW_EN
    tbl.push_back(mk(29'h0000_0001, 16'h8002, 7, 29'h0800_0000, 16'h8000, 16'd27, 1'b0, 1'b1));
`else
    tbl.push_back(mk(29'h0000_0001, 16'h8002, 7, 29'h0800_0000, 16'h7FE7, 16'd27, 1'b0, 1'b0));
`endif
    for (int r = 0; r < 12; r++) begin
      s = MW'($urandom);
      s = s >>> $urandom_range(0, MW - 1);
      tbl.push_back(model(MW'(s), EW'($urandom)));
    end

    step();
    step();
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_man_out", 64'(man_out), 64'd0);
    chk("rst_exp_out", 64'(exp_out), 64'd0);
    chk("rst_lz_out", 64'(lz_out), 64'd0);
    chk("rst_zero_out", {63'd0, zero_out}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_op(tbl[i], (i % 2) == 1, (i == 2) ? 5 : 0);
    end

    // Reset during the third SCAN cycle discards the operand.
    man_in   = 29'h0000_0001;
    exp_in   = 16'd7;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_scan_busy", {63'd0, in_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("mid_rst_man_out", 64'(man_out), 64'd0);
    chk("mid_rst_lz_out", 64'(lz_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_idle", {63'd0, in_ready}, 64'd1);
    chk("post_rst_no_out", {63'd0, out_valid}, 64'd0);

    run_op(model(29'h0000_0010, 16'd2), 1'b0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unum4_norm_seq.md
Name: unum4_norm_seq

Overview:
- Multi-cycle normalizer for unum4 mantissa/exponent pairs.
- Iteratively strips redundant leading sign bits, STEP bits per cycle, using one small leading zeros/ones counter.
- Shifts the mantissa left by the count and decrements the exponent by the same amount.
- Sits between unum4 arithmetic results and the pack/round stage; trades latency for area versus a full-width count-and-shift.

Parameters:
- MAN_MAX_W, 29: mantissa width, two's complement.
- EXP_MAX_W, 16: exponent width, two's complement.
- STEP, 4: sign bits examined and shifted per scan cycle; 1 ≤ STEP < MAN_MAX_W.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept an operand
- man_in  in  MAN_MAX_W  mantissa to normalize
- exp_in  in  EXP_MAX_W  exponent of man_in
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- man_out  out  MAN_MAX_W  normalized mantissa
- exp_out  out  EXP_MAX_W  exp_in minus lz_out
- lz_out  out  EXP_MAX_W  total redundant sign bits removed (N)
- zero_out  out  1  man_in was all zeros

Behaviour:
- One clock domain: clk. rst is asynchronous, active-high.
- Reset forces state IDLE and clears all registers.
  - Reset output values: out_valid=0, man_out=0, exp_out=0, lz_out=0, zero_out=0.
  - in_ready = (state==IDLE), so in_ready=1 during and after reset.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch man_in into the working mantissa and exp_in into the working exponent, clear the count, record zero flag = (man_in==0), then go to SCAN.
  - SCAN: in_ready=0, out_valid=0. Each cycle:
    - window = top STEP+1 bits of the working mantissa.
    - k = number of consecutive equal adjacent pairs in the window, counted from its MSB (0..STEP).
    - k is capped to (MAN_MAX_W-1) - count.
    - Working mantissa shifts left by k with zero fill; working exponent decreases by k; count increases by k.
    - If k<STEP, or count+k == MAN_MAX_W-1, go to DONE.
  - DONE: out_valid=1 and outputs are driven from the working registers. On out_ready, go to IDLE.
- Result hold: while out_valid && !out_ready, all outputs are held stable.
- Latency from accept edge:
  - SCAN cycles = min(floor(N/STEP)+1, ceil((MAN_MAX_W-1)/STEP)).
  - out_valid rises on the cycle after the last SCAN cycle.
- Throughput: one operand in flight.
  - An out_ready handshake in DONE returns to IDLE.
  - The next operand is accepted no earlier than the following cycle; in_ready is never 1 in DONE.
- Arithmetic:
  - count saturates at MAN_MAX_W-1.
  - Exponent subtraction is modulo 2^EXP_MAX_W unless the optional feature is enabled.
- Boundary cases:
  - All zeros: N=MAN_MAX_W-1, man_out=0, zero_out=1.
  - All ones (value -1): N=MAN_MAX_W-1, man_out = only the MSB set, zero_out=0.
  - Already normalized (top two bits differ): N=0, one SCAN cycle.
- rst asserted mid-SCAN or mid-DONE discards the operand; the block returns to the reset state immediately.
- in_valid toggling outside IDLE is ignored.
- X on man_in is irrelevant when no handshake occurs.

Optional Feature:
- Macro: UNUM4_NORM_UFLOW_EN.
- Defined:
  - Adds output port uflow_out (1 bit, reset 0).
  - Exponent update is checked signed. If exp_in - N < -2^(EXP_MAX_W-1), exp_out saturates to -2^(EXP_MAX_W-1) and uflow_out=1 with out_valid.
  - man_out and lz_out are unaffected.
- Undefined: no port; exponent wraps modulo 2^EXP_MAX_W.

Decomposition:
- Shared unum4 package/defs header holds:
  - FSM state localparams (IDLE=0, SCAN=1, DONE=2, 2-bit encoding).
  - MAN_MAX_W/EXP_MAX_W defaults.
  - The macro name.
- One natural sub-module: unum4_clz, instantiated with MAN_MAX_W=STEP+1, EXTRA=0 on the window to produce k.
- Cap, shift, and FSM stay in unum4_norm_seq.

Test Plan (MAN_MAX_W=29, EXP_MAX_W=16, STEP=4):
- Normalized input: man_in=29'h0800_0000, exp_in=5 -> 1 SCAN cycle; man_out=29'h0800_0000, exp_out=5, lz_out=0, zero_out=0.
- Small positive: man_in=29'h0000_0001, exp_in=0 -> 7 SCAN cycles; man_out=29'h0800_0000, exp_out=16'hFFE5 (-27), lz_out=27.
- Negative input: man_in=29'h1F00_0000, exp_in=10 -> 2 SCAN cycles; man_out=29'h1000_0000, exp_out=6, lz_out=4.
- Zero and -1:
  - man_in=0 -> 7 SCAN cycles; lz_out=28, man_out=0, zero_out=1.
  - man_in=29'h1FFF_FFFF -> lz_out=28, man_out=29'h1000_0000, zero_out=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> outputs stable, in_ready=0. Then pulse out_ready -> in_ready=1 the next cycle; a back-to-back operand is accepted there.
- Reset and underflow:
  - Assert rst during the 3rd SCAN cycle -> same cycle out_valid=0, in_ready=1, outputs 0.
  - With UNUM4_NORM_UFLOW_EN: exp_in=16'h8002, man_in=1 -> exp_out=16'h8000, uflow_out=1.
